// File: rtl/sprite_line_fetcher.sv
// Prefetches one sprite row per player from the shared 8-bit flash into ping-pong line
// buffers during horizontal blank; the display reads the bank not currently being written.
module sprite_line_fetcher #(
    parameter int SPRITE_H = 250,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int ADDR_W   = 23
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [12:0]       i_h_cnt,
    input  logic [12:0]       i_v_cnt,
    input  logic [9:0]        i_p1_x,
    input  logic [9:0]        i_p2_x,
    input  logic [9:0]        i_p1_y,
    input  logic [9:0]        i_p2_y,
    input  logic [4:0]        i_p1_gesture,
    input  logic [4:0]        i_p2_gesture,
    output logic              o_fl_req,
    output logic [ADDR_W-1:0] o_fl_addr,
    input  logic              i_fl_ack,
    input  logic              i_fl_valid,
    input  logic [7:0]        i_fl_data,
    output logic              o_lb_we,
    output logic              o_lb_player,
    output logic              o_lb_bank,
    output logic [7:0]        o_lb_addr,
    output logic [7:0]        o_lb_data,
    output logic [1:0]        o_line_on,
    output logic [15:0]       o_line_width,
    output logic              o_busy,
    output logic              o_overrun
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_t;

    function automatic logic [16:0] frame_base(input logic [4:0] g);
        case (g)
            5'd0:    frame_base = 17'd0;
            5'd1:    frame_base = 17'd31250;
            default: frame_base = 17'd68750;
        endcase
    endfunction

    function automatic logic [7:0] frame_width(input logic [4:0] g);
        case (g)
            5'd0:    frame_width = 8'd125;
            5'd1:    frame_width = 8'd150;
            default: frame_width = 8'd200;
        endcase
    endfunction

    // x positions only matter to the pixel mux downstream
    logic unused_x;
    assign unused_x = ^{i_p1_x, i_p2_x};

    logic              trig;
    logic [12:0]       vn, p1_y13, p2_y13, p1_rel, p2_rel;
    logic              p1_on, p2_on;
    logic [7:0]        w1, w2, row1, row2;
    logic [15:0]       prod1, prod2;
    logic [ADDR_W-1:0] p1_start, p2_start;

    assign trig    = (i_h_cnt == 13'(H_ACTIVE));
    assign vn      = (i_v_cnt == 13'(V_TOTAL - 1)) ? 13'd0 : i_v_cnt + 13'd1;
    assign p1_y13  = {3'b000, i_p1_y};
    assign p2_y13  = {3'b000, i_p2_y};
    assign p1_rel  = vn - p1_y13;
    assign p2_rel  = vn - p2_y13;
    assign p1_on   = (vn >= p1_y13) && (p1_rel < 13'(SPRITE_H));
    assign p2_on   = (vn >= p2_y13) && (p2_rel < 13'(SPRITE_H));
    assign row1    = p1_rel[7:0];
    assign row2    = p2_rel[7:0];
    assign w1      = frame_width(i_p1_gesture);
    assign w2      = frame_width(i_p2_gesture);
    assign prod1   = 16'(row1) * 16'(w1);
    assign prod2   = 16'(row2) * 16'(w2);
    assign p1_start = ADDR_W'(frame_base(i_p1_gesture)) + ADDR_W'(prod1);
    assign p2_start = ADDR_W'(frame_base(i_p2_gesture)) + ADDR_W'(prod2);

    state_t            state;
    logic              player;
    logic [7:0]        col, cur_w, p2_w_q;
    logic [ADDR_W-1:0] p2_addr_q;
    logic [1:0]        pend_on;
    logic [15:0]       pend_w;

    assign o_busy = (state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            player       <= 1'b0;
            col          <= '0;
            cur_w        <= '0;
            p2_w_q       <= '0;
            p2_addr_q    <= '0;
            pend_on      <= '0;
            pend_w       <= '0;
            o_fl_req     <= 1'b0;
            o_fl_addr    <= '0;
            o_lb_we      <= 1'b0;
            o_lb_player  <= 1'b0;
            o_lb_bank    <= 1'b0;
            o_lb_addr    <= '0;
            o_lb_data    <= '0;
            o_line_on    <= '0;
            o_line_width <= '0;
            o_overrun    <= 1'b0;
        end else begin
            o_lb_we   <= 1'b0;
            o_overrun <= 1'b0;
            case (state)
                S_IDLE: if (trig) begin
                    // geometry is snapshotted here so mid-fetch gesture/position changes are harmless
                    pend_on   <= {p2_on, p1_on};
                    pend_w    <= {p2_on ? w2 : 8'd0, p1_on ? w1 : 8'd0};
                    p2_w_q    <= w2;
                    p2_addr_q <= p2_start;
                    col       <= '0;
                    if (p1_on) begin
                        state     <= S_ISSUE;
                        player    <= 1'b0;
                        cur_w     <= w1;
                        o_fl_addr <= p1_start;
                        o_fl_req  <= 1'b1;
                    end else if (p2_on) begin
                        state     <= S_ISSUE;
                        player    <= 1'b1;
                        cur_w     <= w2;
                        o_fl_addr <= p2_start;
                        o_fl_req  <= 1'b1;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (trig) begin
                        o_overrun <= 1'b1;
                        o_fl_req  <= 1'b0;
                        state     <= i_fl_ack ? S_DRAIN : S_IDLE;
                    end else if (i_fl_ack) begin
                        o_fl_req <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (trig) begin
                        // a byte landing in the same cycle is simply dropped: nothing left to drain
                        o_overrun <= 1'b1;
                        state     <= i_fl_valid ? S_IDLE : S_DRAIN;
                    end else if (i_fl_valid) begin
                        o_lb_we     <= 1'b1;
                        o_lb_player <= player;
                        o_lb_addr   <= col;
                        o_lb_data   <= i_fl_data;
                        if (col == cur_w - 8'd1) begin
                            if (!player && pend_on[1]) begin
                                player    <= 1'b1;
                                col       <= '0;
                                cur_w     <= p2_w_q;
                                o_fl_addr <= p2_addr_q;
                                o_fl_req  <= 1'b1;
                                state     <= S_ISSUE;
                            end else begin
                                state <= S_DONE;
                            end
                        end else begin
                            col       <= col + 8'd1;
                            o_fl_addr <= o_fl_addr + ADDR_W'(1);
                            o_fl_req  <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    o_lb_bank    <= ~o_lb_bank;
                    o_line_on    <= pend_on;
                    o_line_width <= pend_w;
                    state        <= S_IDLE;
                end
                S_DRAIN: if (i_fl_valid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
